// File: rtl/fifo_gen_dist_ram_param.sv
// Parametrised single-clock FIFO on distributed RAM with standard or first-word-fall-through read.
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo_gen_dist_ram_param #(
    parameter int WIDTH      = 9,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int PROG_FULL  = 14,
    parameter int PROG_EMPTY = 5,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic             prog_full,
    output logic             prog_empty,
    output logic [CNT_W-1:0] data_count,
    output logic             wr_ack,
    output logic             overflow,
`ifdef FIFO_ALMOST_FLAGS_EN
    output logic             almost_full,
    output logic             almost_empty,
`endif
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PF_C    = CNT_W'(PROG_FULL);
    localparam logic [CNT_W-1:0] PE_C    = CNT_W'(PROG_EMPTY);

    typedef enum logic {S_EMPTY, S_HOLD} out_state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] ram_count;
    out_state_t       state;
    out_state_t       state_next;
    logic             held;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_pop;

    assign data_count = count;

    // count includes the FWFT output register; ram_count is what still sits in the RAM
    always_comb begin
        held       = (FWFT != 0) && (state == S_HOLD);
        ram_count  = count - CNT_W'(held);
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        ram_pop    = 1'b0;
        state_next = state;
        if (FWFT != 0) begin
            if (state == S_EMPTY) begin
                if (ram_count != '0) begin
                    ram_pop    = 1'b1;
                    state_next = S_HOLD;
                end
            end else if (rd_acc) begin
                if (ram_count != '0) begin
                    ram_pop = 1'b1;
                end else begin
                    state_next = S_EMPTY;
                end
            end
        end else begin
            ram_pop = rd_acc;
        end
    end

    // Storage is never reset; only pointers decide what is visible
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            state        <= S_EMPTY;
            dout         <= '0;
            valid        <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            prog_full    <= 1'b0;
            prog_empty   <= 1'b1;
            wr_ack       <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
`endif
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            state      <= state_next;
            count      <= count_next;
            full       <= (count_next == DEPTH_C);
            prog_full  <= (count_next >= PF_C);
            prog_empty <= (count_next <= PE_C);
            if (FWFT != 0) begin
                empty <= (state_next != S_HOLD);
                valid <= (state_next == S_HOLD);
            end else begin
                empty <= (count_next == '0);
                valid <= rd_acc;
            end
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
`ifdef FIFO_ALMOST_FLAGS_EN
            almost_full  <= (count_next >= CNT_W'(DEPTH - 1));
            almost_empty <= (count_next <= CNT_W'(1));
`endif
        end
    end

endmodule

// File: tb/tb_fifo_gen_dist_ram_param.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO (DEPTH=16), plus a DEPTH=8 instance
// for almost flags when FIFO_ALMOST_FLAGS_EN is defined.
module tb_fifo_gen_dist_ram_param;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // standard-mode instance
    logic [8:0] s_din, s_dout;
    logic       s_wr_en, s_rd_en, s_valid, s_full, s_empty, s_pf, s_pe;
    logic [4:0] s_cnt;
    logic       s_ack, s_ovf, s_udf;
    // FWFT instance
    logic [8:0] f_din, f_dout;
    logic       f_wr_en, f_rd_en, f_valid, f_full, f_empty, f_pf, f_pe;
    logic [4:0] f_cnt;
    logic       f_ack, f_ovf, f_udf;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic       s_af, s_ae, f_af, f_ae;
    logic [7:0] a_din, a_dout;
    logic       a_wr_en, a_rd_en, a_valid, a_full, a_empty, a_pf, a_pe;
    logic [3:0] a_cnt;
    logic       a_ack, a_ovf, a_udf, a_af, a_ae;
`endif

    fifo_gen_dist_ram_param #(.WIDTH(9), .DEPTH(16), .FWFT(0), .PROG_FULL(14), .PROG_EMPTY(5)) u_std (
        .clk(clk), .srst(srst), .din(s_din), .wr_en(s_wr_en), .rd_en(s_rd_en),
        .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
        .prog_full(s_pf), .prog_empty(s_pe), .data_count(s_cnt),
        .wr_ack(s_ack), .overflow(s_ovf),
`ifdef FIFO_ALMOST_FLAGS_EN
        .almost_full(s_af), .almost_empty(s_ae),
`endif
        .underflow(s_udf)
    );

    fifo_gen_dist_ram_param #(.WIDTH(9), .DEPTH(16), .FWFT(1), .PROG_FULL(14), .PROG_EMPTY(5)) u_fwft (
        .clk(clk), .srst(srst), .din(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
        .prog_full(f_pf), .prog_empty(f_pe), .data_count(f_cnt),
        .wr_ack(f_ack), .overflow(f_ovf),
`ifdef FIFO_ALMOST_FLAGS_EN
        .almost_full(f_af), .almost_empty(f_ae),
`endif
        .underflow(f_udf)
    );

`ifdef FIFO_ALMOST_FLAGS_EN
    fifo_gen_dist_ram_param #(.WIDTH(8), .DEPTH(8), .FWFT(0), .PROG_FULL(6), .PROG_EMPTY(2)) u_alm (
        .clk(clk), .srst(srst), .din(a_din), .wr_en(a_wr_en), .rd_en(a_rd_en),
        .dout(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
        .prog_full(a_pf), .prog_empty(a_pe), .data_count(a_cnt),
        .wr_ack(a_ack), .overflow(a_ovf),
        .almost_full(a_af), .almost_empty(a_ae),
        .underflow(a_udf)
    );
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1;
        s_din = '0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        f_din = '0; f_wr_en = 1'b0; f_rd_en = 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
        a_din = '0; a_wr_en = 1'b0; a_rd_en = 1'b0;
`endif
        tick();
        tick();
        srst = 1'b0;

        // reset state
        chk("rst_empty", s_empty, 1);
        chk("rst_full", s_full, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_dout", s_dout, 0);
        chk("rst_cnt", s_cnt, 0);
        chk("rst_pe", s_pe, 1);
        chk("rst_pf", s_pf, 0);
        chk("rst_ack", {s_ack, s_ovf, s_udf}, 0);
        chk("rst_f_empty", f_empty, 1);
        chk("rst_f_valid", f_valid, 0);

        // fill 16 words
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1; s_din = 9'(i);
            tick();
            chk($sformatf("fill_ack%0d", i), s_ack, 1);
            chk($sformatf("fill_cnt%0d", i), s_cnt, i + 1);
            chk($sformatf("fill_pf%0d", i), s_pf, (i + 1) >= 14);
            chk($sformatf("fill_full%0d", i), s_full, (i + 1) == 16);
        end

        // write into full FIFO
        s_din = 9'h1AA;
        tick();
        chk("ovf", s_ovf, 1);
        chk("ovf_ack", s_ack, 0);
        chk("ovf_cnt", s_cnt, 16);
        s_wr_en = 1'b0;

        // drain 16 words
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1'b1;
            tick();
            if (i == 0) chk("ovf_pulse", s_ovf, 0);
            chk($sformatf("rd_valid%0d", i), s_valid, 1);
            chk($sformatf("rd_dout%0d", i), s_dout, i);
            chk($sformatf("rd_cnt%0d", i), s_cnt, 15 - i);
            chk($sformatf("rd_pe%0d", i), s_pe, (15 - i) <= 5);
            chk($sformatf("rd_empty%0d", i), s_empty, i == 15);
        end

        // read from empty FIFO
        tick();
        chk("udf", s_udf, 1);
        chk("udf_valid", s_valid, 0);
        chk("udf_dout", s_dout, 9'h00F);
        s_rd_en = 1'b0;
        tick();
        chk("udf_pulse", s_udf, 0);

        // preload 5 words, then 40 cycles of simultaneous read/write across pointer wrap
        for (int k = 0; k < 5; k++) begin
            s_wr_en = 1'b1; s_din = 9'(9'h100 + k);
            tick();
        end
        chk("pre_cnt", s_cnt, 5);
        for (int j = 0; j < 40; j++) begin
            s_wr_en = 1'b1; s_rd_en = 1'b1; s_din = 9'(9'h105 + j);
            tick();
            chk($sformatf("rw_dout%0d", j), s_dout, 9'h100 + j);
            chk($sformatf("rw_cnt%0d", j), s_cnt, 5);
            chk($sformatf("rw_ack%0d", j), {s_ack, s_valid}, 2'b11);
        end
        s_rd_en = 1'b0;

        // grow to 10 words, then reset mid-stream
        for (int k = 0; k < 5; k++) begin
            s_din = 9'(9'h140 + k);
            tick();
        end
        s_wr_en = 1'b0;
        chk("ten_cnt", s_cnt, 10);
        chk("ten_pe", s_pe, 0);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_cnt", s_cnt, 0);
        chk("srst_empty", s_empty, 1);
        chk("srst_valid", s_valid, 0);
        chk("srst_pe", s_pe, 1);
        chk("srst_dout", s_dout, 0);

        // read+write on empty: only the write is taken
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_din = 9'h055;
        tick();
        chk("erw_udf", s_udf, 1);
        chk("erw_ack", s_ack, 1);
        chk("erw_cnt", s_cnt, 1);
        chk("erw_valid", s_valid, 0);
        s_wr_en = 1'b0;
        tick();
        s_rd_en = 1'b0;
        chk("post_rst_dout", s_dout, 9'h055);
        chk("post_rst_valid", s_valid, 1);
        chk("post_rst_empty", s_empty, 1);

        // FWFT: single write falls through two edges later
        f_wr_en = 1'b1; f_din = 9'h123;
        tick();
        f_wr_en = 1'b0;
        chk("fw_n_empty", f_empty, 1);
        chk("fw_n_valid", f_valid, 0);
        chk("fw_n_cnt", f_cnt, 1);
        tick();
        chk("fw_n1_dout", f_dout, 9'h123);
        chk("fw_n1_valid", f_valid, 1);
        chk("fw_n1_empty", f_empty, 0);
        chk("fw_n1_cnt", f_cnt, 1);
        for (int k = 1; k < 4; k++) begin
            f_wr_en = 1'b1; f_din = 9'(9'h123 + k);
            tick();
        end
        f_wr_en = 1'b0;
        chk("fw_q_cnt", f_cnt, 4);
        chk("fw_q_dout", f_dout, 9'h123);

        // back-to-back reads of the queued words
        f_rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fw_rd_dout%0d", k), f_dout, 9'h124 + k);
            chk($sformatf("fw_rd_valid%0d", k), f_valid, 1);
            chk($sformatf("fw_rd_cnt%0d", k), f_cnt, 3 - k);
        end
        tick();
        chk("fw_end_empty", f_empty, 1);
        chk("fw_end_valid", f_valid, 0);
        chk("fw_end_cnt", f_cnt, 0);
        tick();
        chk("fw_udf", f_udf, 1);
        f_rd_en = 1'b0;

`ifdef FIFO_ALMOST_FLAGS_EN
        chk("alm_rst_ae", a_ae, 1);
        chk("alm_rst_af", a_af, 0);
        for (int c = 1; c <= 8; c++) begin
            a_wr_en = 1'b1; a_din = 8'(c);
            tick();
            chk($sformatf("alm_ae%0d", c), a_ae, c <= 1);
            chk($sformatf("alm_af%0d", c), a_af, c >= 7);
        end
        a_wr_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/fifo_gen_dist_ram_param.md
Name: fifo_gen_dist_ram_param

Overview:
- Parametrised, behavioural synchronous FIFO built on distributed RAM.
- Successor to the fixed-size 16x9 wrapper. Generalised in width, depth and thresholds.
- Adds a first-word-fall-through (FWFT) read mode, write acknowledge, and overflow/underflow status.
- Used as the drop-in FIFO for the test benches and the I/O datapaths in a single clock domain.

Parameters:
WIDTH, 9, data word width in bits (1..64)
DEPTH, 16, storage words; power of 2, 4..1024
FWFT, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
PROG_FULL, 14, prog_full asserts when count >= PROG_FULL (1..DEPTH)
PROG_EMPTY, 5, prog_empty asserts when count <= PROG_EMPTY (0..DEPTH-1)
CNT_W, $clog2(DEPTH)+1, data_count width; derived, do not override

Ports:
clk  in  1  single clock; all logic on rising edge
srst  in  1  reset; synchronous, active-high
din  in  WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request (FWFT: acknowledge of the current dout)
dout  out  WIDTH  read data
valid  out  1  dout holds a valid word
full  out  1  count == DEPTH
empty  out  1  no word available to the reader
prog_full  out  1  count >= PROG_FULL
prog_empty  out  1  count <= PROG_EMPTY
data_count  out  CNT_W  occupancy, 0..DEPTH, no wrap
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected
underflow  out  1  previous-cycle read rejected

Behaviour:
- Reset (srst=1 at an edge):
  - Pointers = 0, count = 0, dout = 0.
  - valid = 0, full = 0, empty = 1, prog_full = 0, prog_empty = 1.
  - wr_ack, overflow and underflow = 0.
  - srst dominates wr_en/rd_en. RAM contents are not cleared.
  - A reset mid-stream discards all data.
- Accept rules:
  - Write accepted iff wr_en && !full. Read accepted iff rd_en && !empty.
  - Flags used are the registered values from the current cycle.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
  - When full, a read plus write accepts only the read; overflow is set.
  - When empty, a read plus write accepts only the write; underflow is set.
- Pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count tracks the total words held, including the FWFT output register, and is 0..DEPTH.
- All status outputs are registered and update on the same edge as count:
  - full = (count == DEPTH)
  - prog_full = (count >= PROG_FULL)
  - prog_empty = (count <= PROG_EMPTY)
  - data_count = count
- wr_ack/overflow/underflow are single-cycle pulses, one cycle after the offending or accepted request.
- Standard mode (FWFT=0):
  - empty = (count == 0).
  - An accepted read at edge N updates dout at that edge; valid = 1 for that one cycle only.
  - dout otherwise holds its last value and valid = 0.
  - Write-to-read path: a write at edge N clears empty after edge N; a read may be issued the next cycle.
- FWFT mode (FWFT=1):
  - Output register state machine with states EMPTY and HOLD.
  - EMPTY -> HOLD: the edge after the RAM holds >= 1 word. A write at edge N shows on dout after edge N+1.
  - HOLD & rd_en: if the RAM holds more words, reload the next word in the same edge (back-to-back reads sustain 1 word/cycle); otherwise go to EMPTY.
  - In FWFT mode, valid = !empty = (state == HOLD).
  - rd_en in EMPTY is rejected and flagged as underflow.
- Width rules:
  - data_count never wraps; for DEPTH=16 it reaches 16 = 5'b10000.
  - Threshold compares are unsigned on CNT_W bits.

Optional Feature:
FIFO_ALMOST_FLAGS_EN
- Defined: adds outputs almost_full and almost_empty, both registered.
  - almost_full = (count >= DEPTH-1).
  - almost_empty = (count <= 1).
  - Reset values: almost_full = 0, almost_empty = 1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- DEPTH=16, FWFT=0: reset, write 0x000..0x00F on 16 consecutive cycles -> wr_ack for each, full=1 after the 16th, data_count=16, prog_full set after the 14th write.
- Full FIFO plus wr_en with din=0x1AA -> overflow=1 for one cycle, data_count stays 16. Then 16 reads -> dout 0x000..0x00F with valid one cycle after each rd_en; empty=1 after the last read; prog_empty set when count <= 5.
- Empty FIFO, rd_en=1 -> underflow=1, valid=0, dout unchanged. With count=5, wr_en and rd_en held for 40 cycles -> count stays 5 and the data order is preserved across pointer wrap.
- FWFT=1: write 0x123 at edge N -> dout=0x123, valid=1, empty=0 after edge N+1 with no rd_en. With 4 words queued, rd_en held high -> 4 words on consecutive cycles, then empty=1.
- Load 10 words, assert srst for 1 cycle -> count=0, empty=1, valid=0, prog_empty=1. The next write of 0x055 reads back 0x055, not stale data.
- With FIFO_ALMOST_FLAGS_EN defined, DEPTH=8 -> almost_full rises at count=7 and almost_empty falls at count=2.
